bp_me_prefetch_issue: RTL and testbench

BP_ME_PREFETCH_ISSUE -- requirements
Module: bp_me_prefetch_issue

---
 rtl/bp_me_prefetch_issue.sv | 199 +++++++++++++++++++
 tb/tb_bp_me_prefetch_issue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_prefetch_issue.sv
// Prefetch issue stage: arbitrates demand DMA packets against queued offset prefetches
// and tags returning fills. Optional macro BP_ME_PREFETCH_PAGE_CHECK_EN drops page-crossing candidates.
module bp_me_prefetch_issue #(
   parameter int unsigned daddr_width_p        = 28,
   parameter int unsigned lg_offsets_p         = 6,
   parameter int unsigned block_offset_width_p = 6,
   parameter int unsigned page_offset_width_p  = 12,
   parameter int unsigned queue_els_p          = 8,
   parameter int unsigned max_reads_p          = 4,
   parameter int unsigned fill_beats_p         = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [daddr_width_p-1:0] demand_addr_i,
   input  logic                     demand_write_i,
   input  logic                     demand_v_i,
   output logic                     demand_yumi_o,
   input  logic [lg_offsets_p-1:0]  offset_i,
   input  logic                     offset_v_i,
   output logic [daddr_width_p-1:0] dma_addr_o,
   output logic                     dma_write_o,
   output logic                     dma_v_o,
   input  logic                     dma_ready_and_i,
   input  logic                     fill_beat_i,
   output logic                     prefetch_fill_o,
   output logic                     dropped_o
);

   localparam int unsigned QW  = (queue_els_p > 1) ? $clog2(queue_els_p) : 1;
   localparam int unsigned QCW = $clog2(queue_els_p + 1);
   localparam int unsigned RW  = (max_reads_p > 1) ? $clog2(max_reads_p) : 1;
   localparam int unsigned RCW = $clog2(max_reads_p + 1);
   localparam int unsigned BW  = (fill_beats_p > 1) ? $clog2(fill_beats_p) : 1;

   if (page_offset_width_p < block_offset_width_p) begin : g_bad_cfg
      $error("bp_me_prefetch_issue: page_offset_width_p must be >= block_offset_width_p");
   end

   // Pending-prefetch queue
   logic [daddr_width_p-1:0] pq_mem_q [queue_els_p];
   logic [QW-1:0]            pq_head_q, pq_head_d;
   logic [QW-1:0]            pq_tail_q, pq_tail_d;
   logic [QCW-1:0]           pq_cnt_q, pq_cnt_d;
   logic                     pq_empty, pq_full, pq_enq, pq_deq, pq_drop;

   // Read-order FIFO: one bit per outstanding read, 1 = prefetch
   logic [max_reads_p-1:0]   ro_mem_q;
   logic [RW-1:0]            ro_head_q, ro_head_d;
   logic [RW-1:0]            ro_tail_q, ro_tail_d;
   logic [RCW-1:0]           ro_cnt_q, ro_cnt_d;
   logic                     ro_empty, ro_full, ro_push, ro_pop;

   logic [BW-1:0]            beat_q, beat_d;

   logic [daddr_width_p-1:0] last_q, last_d;
   logic [daddr_width_p-1:0] enq_addr_q, enq_addr_d;
   logic                     enq_v_q, enq_v_d;

   logic                     sel_demand, rd_req, xfer, pf_xfer, demand_rd_xfer;
   logic [daddr_width_p-1:0] line_base, off_shift, cand;
   logic                     page_ok, cand_keep;

   assign pq_empty = (pq_cnt_q == '0);
   assign pq_full  = (pq_cnt_q == QCW'(queue_els_p));
   assign ro_empty = (ro_cnt_q == '0);
   assign ro_full  = (ro_cnt_q == RCW'(max_reads_p));

   // Arbitration: demand always wins; reads wait while max_reads_p are outstanding
   always_comb begin
      sel_demand  = demand_v_i;
      rd_req      = sel_demand ? ~demand_write_i : 1'b1;
      dma_v_o     = ~reset_i & (sel_demand | ~pq_empty) & ~(rd_req & ro_full);
      dma_addr_o  = sel_demand ? demand_addr_i : pq_mem_q[pq_head_q];
      dma_write_o = sel_demand & demand_write_i;
      xfer        = dma_v_o & dma_ready_and_i;
      demand_yumi_o  = xfer & sel_demand;
      pf_xfer        = xfer & ~sel_demand;
      demand_rd_xfer = demand_yumi_o & ~demand_write_i;
   end

   always_comb begin
      line_base = {demand_addr_i[daddr_width_p-1:block_offset_width_p],
                   {block_offset_width_p{1'b0}}};
      off_shift = daddr_width_p'(offset_i) << block_offset_width_p;
      cand      = line_base + off_shift;
`ifdef BP_ME_PREFETCH_PAGE_CHECK_EN
      page_ok   = (cand[daddr_width_p-1:page_offset_width_p]
                   == demand_addr_i[daddr_width_p-1:page_offset_width_p]);
`else
      page_ok   = 1'b1;
`endif
      cand_keep = offset_v_i & (offset_i != '0) & (cand != last_q) & page_ok;
   end

   // last_q tracks the candidate as soon as it is accepted, so a back-to-back
   // duplicate is rejected even while the first is still waiting to enqueue.
   always_comb begin
      enq_v_d    = 1'b0;
      enq_addr_d = enq_addr_q;
      last_d     = last_q;
      if (demand_rd_xfer && cand_keep) begin
         enq_v_d    = 1'b1;
         enq_addr_d = cand;
         last_d     = cand;
      end
   end

   always_comb begin
      pq_enq    = enq_v_q;
      pq_deq    = pf_xfer;
      pq_drop   = pq_enq & pq_full & ~pq_deq;
      pq_head_d = pq_head_q;
      pq_tail_d = pq_tail_q;
      pq_cnt_d  = pq_cnt_q;
      if (pq_deq || pq_drop) begin
         pq_head_d = (pq_head_q == QW'(queue_els_p - 1)) ? '0 : pq_head_q + QW'(1);
      end
      if (pq_enq) begin
         pq_tail_d = (pq_tail_q == QW'(queue_els_p - 1)) ? '0 : pq_tail_q + QW'(1);
      end
      case ({pq_enq, pq_deq | pq_drop})
         2'b10:   pq_cnt_d = pq_cnt_q + QCW'(1);
         2'b01:   pq_cnt_d = pq_cnt_q - QCW'(1);
         default: pq_cnt_d = pq_cnt_q;
      endcase
   end

   always_comb begin
      ro_push   = xfer & rd_req;
      ro_pop    = fill_beat_i & ~ro_empty & (beat_q == BW'(fill_beats_p - 1));
      beat_d    = beat_q;
      ro_head_d = ro_head_q;
      ro_tail_d = ro_tail_q;
      ro_cnt_d  = ro_cnt_q;
      if (fill_beat_i && !ro_empty) begin
         beat_d = ro_pop ? '0 : beat_q + BW'(1);
      end
      if (ro_pop) begin
         ro_head_d = (ro_head_q == RW'(max_reads_p - 1)) ? '0 : ro_head_q + RW'(1);
      end
      if (ro_push) begin
         ro_tail_d = (ro_tail_q == RW'(max_reads_p - 1)) ? '0 : ro_tail_q + RW'(1);
      end
      case ({ro_push, ro_pop})
         2'b10:   ro_cnt_d = ro_cnt_q + RCW'(1);
         2'b01:   ro_cnt_d = ro_cnt_q - RCW'(1);
         default: ro_cnt_d = ro_cnt_q;
      endcase
   end

   assign prefetch_fill_o = ~reset_i & ~ro_empty & ro_mem_q[ro_head_q];
   assign dropped_o       = ~reset_i & pq_drop;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pq_head_q  <= '0;
         pq_tail_q  <= '0;
         pq_cnt_q   <= '0;
         ro_head_q  <= '0;
         ro_tail_q  <= '0;
         ro_cnt_q   <= '0;
         beat_q     <= '0;
         last_q     <= '0;
         enq_addr_q <= '0;
         enq_v_q    <= 1'b0;
      end else begin
         pq_head_q  <= pq_head_d;
         pq_tail_q  <= pq_tail_d;
         pq_cnt_q   <= pq_cnt_d;
         ro_head_q  <= ro_head_d;
         ro_tail_q  <= ro_tail_d;
         ro_cnt_q   <= ro_cnt_d;
         beat_q     <= beat_d;
         last_q     <= last_d;
         enq_addr_q <= enq_addr_d;
         enq_v_q    <= enq_v_d;
      end
   end

   // Storage arrays carry no reset; validity comes from the counters above
   always_ff @(posedge clk_i) begin
      if (pq_enq) begin
         pq_mem_q[pq_tail_q] <= enq_addr_q;
      end
      if (ro_push) begin
         ro_mem_q[ro_tail_q] <= ~sel_demand;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(fill_beat_i && ro_empty))
            else $error("bp_me_prefetch_issue: fill beat with no outstanding read");
      end
   end
`endif

endmodule

// File: tb/tb_bp_me_prefetch_issue.sv
// Directed and random checks of bp_me_prefetch_issue against a queue-based reference model.
module tb_bp_me_prefetch_issue;

   localparam int QN = 8;
   localparam int MR = 4;
   localparam int FB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [27:0] da  = '0;
   logic        dw  = 1'b0;
   logic        dv  = 1'b0;
   logic [5:0]  off = '0;
   logic        ov  = 1'b0;
   logic        rdy = 1'b0;
   logic        fb  = 1'b0;
   logic        yumi, dwr, dmav, pff, drp;
   logic [27:0] daddr;

   always #5 clk = ~clk;

   bp_me_prefetch_issue #(
      .daddr_width_p(28), .lg_offsets_p(6), .block_offset_width_p(6),
      .page_offset_width_p(12), .queue_els_p(QN), .max_reads_p(MR), .fill_beats_p(FB)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .demand_addr_i(da), .demand_write_i(dw), .demand_v_i(dv), .demand_yumi_o(yumi),
      .offset_i(off), .offset_v_i(ov),
      .dma_addr_o(daddr), .dma_write_o(dwr), .dma_v_o(dmav), .dma_ready_and_i(rdy),
      .fill_beat_i(fb), .prefetch_fill_o(pff), .dropped_o(drp)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [27:0] m_pq[$];
   bit          m_ro[$];
   int          m_beats;
   logic [27:0] m_last;
   bit          m_pend;
   logic [27:0] m_pend_a;

   // Observations taken from the DUT pins
   logic [27:0] pf_log[$];
   int          drop_cnt;
   int          pf_beat_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pq.delete();
      m_ro.delete();
      m_beats  = 0;
      m_last   = '0;
      m_pend   = 0;
      m_pend_a = '0;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model at the edge
   task automatic cycle();
      bit ev, ew, ey, ep, ed, blk, xfer, keep;
      logic [27:0] ea, cand;
      #4;
      blk = (m_ro.size() == MR);
      if (rst)     ev = 0;
      else if (dv) ev = dw || !blk;
      else         ev = (m_pq.size() != 0) && !blk;
      ea   = dv ? da : ((m_pq.size() != 0) ? m_pq[0] : '0);
      ew   = dv && dw;
      xfer = ev && rdy;
      ey   = xfer && dv;
      ep   = !rst && (m_ro.size() != 0) && m_ro[0];
      ed   = !rst && m_pend && (m_pq.size() == QN) && !(xfer && !dv);
      chk("dma_v", dmav, ev);
      if (ev) begin
         chk("dma_addr", daddr, ea);
         chk("dma_write", dwr, ew);
      end
      chk("demand_yumi", yumi, ey);
      chk("prefetch_fill", pff, ep);
      chk("dropped", drp, ed);
      if (dmav && rdy && !dv) pf_log.push_back(daddr);
      if (drp) drop_cnt++;
      if (fb && pff) pf_beat_cnt++;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (fb && m_ro.size() != 0) begin
            m_beats++;
            if (m_beats == FB) begin
               m_beats = 0;
               void'(m_ro.pop_front());
            end
         end
         if (xfer && !ew) m_ro.push_back(!dv);
         if (xfer && !dv) void'(m_pq.pop_front());
         if (m_pend) begin
            m_pq.push_back(m_pend_a);
            if (m_pq.size() > QN) void'(m_pq.pop_front());
         end
         m_pend = 0;
         if (xfer && dv && !dw) begin
            cand = 28'((longint'(da) / 64 + longint'(off)) * 64 % 268435456);
            keep = ov && (off != 0) && (cand != m_last);
`ifdef BP_ME_PREFETCH_PAGE_CHECK_EN
            if (longint'(cand) / 4096 != longint'(da) / 4096) keep = 0;
`endif
            if (keep) begin
               m_pend   = 1;
               m_pend_a = cand;
               m_last   = cand;
            end
         end
      end
      #1;
   endtask

   task automatic drain();
      dv  = 0;
      ov  = 0;
      rdy = 1;
      for (int k = 0; k < 300; k++) begin
         if (m_ro.size() == 0 && m_pq.size() == 0 && !m_pend) break;
         fb = (m_ro.size() != 0);
         cycle();
      end
      fb = 0;
      #1;
      chk("drain_idle_v", dmav, 0);
   endtask

   task automatic basic_miss();
      pf_log.delete();
      pf_beat_cnt = 0;
      da = 28'h1040; dw = 0; dv = 1; off = 6'd2; ov = 1; rdy = 1;
      cycle();
      dv = 0; ov = 0;
      cycle();
      cycle();
      for (int b = 0; b < 8; b++) begin
         fb = 1;
         cycle();
      end
      fb = 0;
      chk("miss_pf_count", pf_log.size(), 1);
      if (pf_log.size() != 0) chk("miss_pf_addr", pf_log[0], 28'h10C0);
      chk("miss_pf_beats", pf_beat_cnt, 4);
   endtask

   initial begin
      int i, guard;
      bit acc, found;
      model_reset();
      drop_cnt = 0;
      pf_beat_cnt = 0;
      rst = 1;
      @(posedge clk); #1;
      cycle();
      rst = 0;

      // Basic miss with prefetch
      basic_miss();
      drain();

      // Page-crossing candidate
      pf_log.delete();
      da = 28'h1FC0; dw = 0; dv = 1; off = 6'd1; ov = 1; rdy = 1;
      cycle();
      drain();
`ifdef BP_ME_PREFETCH_PAGE_CHECK_EN
      chk("page_pf_count", pf_log.size(), 0);
`else
      chk("page_pf_count", pf_log.size(), 1);
      if (pf_log.size() != 0) chk("page_pf_addr", pf_log[0], 28'h2000);
`endif

      // Nine misses with demand held: oldest candidate dropped
      pf_log.delete();
      drop_cnt = 0;
      i = 0;
      guard = 0;
      while (i < 9 && guard < 400) begin
         dv = 1; dw = 0; da = 28'h10000 + 28'(i) * 28'h1000; off = 6'd1; ov = 1; rdy = 1;
         fb = (m_ro.size() != 0);
         acc = (m_ro.size() < MR);
         cycle();
         if (acc) i++;
         guard++;
      end
      chk("nine_accepted", i, 9);
      dv = 1; dw = 1; da = 28'h7000; ov = 0; fb = (m_ro.size() != 0);
      cycle();
      dw = 0;
      chk("drop_pulses", drop_cnt, 1);
      drain();
      chk("nine_pf_count", pf_log.size(), 8);
      if (pf_log.size() != 0) chk("nine_pf_first", pf_log[0], 28'h11040);
      found = 0;
      foreach (pf_log[k]) if (pf_log[k] == 28'h10040) found = 1;
      chk("first_cand_issued", found, 0);

      // Read limit: writes bypass, reads stall until a fill completes
      for (int r = 0; r < 4; r++) begin
         dv = 1; dw = 0; da = 28'h5000 + 28'(r) * 28'h40; ov = 0; rdy = 1; fb = 0;
         cycle();
      end
      dw = 1; da = 28'h3000;
      #1;
      chk("limit_write_v", dmav, 1);
      cycle();
      dw = 0; da = 28'h4000;
      #1;
      chk("limit_read_stall", dmav, 0);
      for (int b = 0; b < 4; b++) begin
         fb = 1;
         cycle();
      end
      fb = 0;
      #1;
      chk("limit_read_v", dmav, 1);
      chk("limit_read_addr", daddr, 28'h4000);
      cycle();
      drain();

      // Reset mid-fill, then normal operation resumes
      da = 28'h1040; dw = 0; dv = 1; off = 6'd2; ov = 1; rdy = 1;
      cycle();
      dv = 0; ov = 0;
      cycle();
      cycle();
      fb = 1;
      cycle();
      cycle();
      fb = 0;
      rst = 1;
      cycle();
      rst = 0;
      #1;
      chk("post_reset_v", dmav, 0);
      chk("post_reset_pf", pff, 0);
      chk("post_reset_drop", drp, 0);
      cycle();
      basic_miss();
      drain();

      // Duplicate candidate and zero offset
      pf_log.delete();
      dv = 1; dw = 0; da = 28'h6000; off = 6'd1; ov = 1; rdy = 1;
      cycle();
      da = 28'h6010;
      cycle();
      drain();
      chk("dup_pf_count", pf_log.size(), 1);
      pf_log.delete();
      dv = 1; dw = 0; da = 28'h7000; off = 6'd0; ov = 1; rdy = 1;
      cycle();
      drain();
      chk("zero_off_pf_count", pf_log.size(), 0);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         dv  = ($urandom_range(0, 3) != 0);
         dw  = ($urandom_range(0, 3) == 0);
         da  = 28'($urandom_range(0, 63) * 64 + $urandom_range(0, 63));
         off = 6'($urandom_range(0, 3));
         ov  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         fb  = !rst && (m_ro.size() != 0) && ($urandom_range(0, 1) == 1);
         cycle();
      end
      rst = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
